// File: rtl/ladybird_addr_router.sv
// ladybird_addr_router: decodes one upstream core request stream onto
// NUM_REGION downstream targets using a base/mask table. It flags each request
// as cacheable or not, and tracks accepted requests in order so that responses
// return upstream in issue order. Unmapped requests get a locally generated
// error response.
module ladybird_addr_router #(
  parameter int XLEN            = 32,
  parameter int NUM_REGION      = 6,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [NUM_REGION-1:0][XLEN-1:0] REGION_BASE = {
    32'h0000_0000, 32'h4000_0000, 32'h2000_0000,
    32'h1000_0000, 32'h8000_0000, 32'h0000_1000},
  parameter logic [NUM_REGION-1:0][XLEN-1:0] REGION_MASK = {
    32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
    32'hFFFF_0000, 32'h8000_0000, 32'hFFFF_F000},
  parameter logic [NUM_REGION-1:0] REGION_CACHEABLE = 6'b000011,
  parameter logic [XLEN-1:0]       ERR_RDATA        = 32'h0000_0000
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [XLEN-1:0]                req_addr,
  input  logic                           req_we,
  input  logic [XLEN-1:0]                req_wdata,
  input  logic [XLEN/8-1:0]              req_strb,
  output logic                           req_uncachable,
  output logic [NUM_REGION-1:0]          dn_valid,
  input  logic [NUM_REGION-1:0]          dn_ready,
  output logic [XLEN-1:0]                dn_addr,
  output logic                           dn_we,
  output logic [XLEN-1:0]                dn_wdata,
  output logic [XLEN/8-1:0]              dn_strb,
  input  logic [NUM_REGION-1:0]          dn_rvalid,
  output logic [NUM_REGION-1:0]          dn_rready,
  input  logic [NUM_REGION*XLEN-1:0]     dn_rdata,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [XLEN-1:0]                resp_data,
  output logic                           resp_err,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);

  // Tag value NUM_REGION is reserved to mean "unmapped, answer with an error".
  localparam int TAG_W = $clog2(NUM_REGION + 1);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TAG_W-1:0] ERR_TAG = TAG_W'(NUM_REGION);

  logic [TAG_W-1:0]      tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, empty;
  logic                  dec_hit, dec_cache, dec_ready;
  logic [TAG_W-1:0]      dec_tag;
  logic [NUM_REGION-1:0] dec_onehot;
  logic [TAG_W-1:0]      head_tag;
  logic                  head_rvalid;
  logic [XLEN-1:0]       head_rdata;
  logic                  resp_free;
  logic                  push, map_pop, err_pop, pop;

  assign full      = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty     = (count == '0);
  assign resp_free = ~resp_valid | resp_ready;

  // Priority decode: scanning from the top down lets the lowest matching index win.
  always_comb begin
    dec_hit    = 1'b0;
    dec_tag    = ERR_TAG;
    dec_cache  = 1'b0;
    dec_ready  = 1'b0;
    dec_onehot = '0;
    for (int i = NUM_REGION - 1; i >= 0; i--) begin
      if ((req_addr & REGION_MASK[i]) == REGION_BASE[i]) begin
        dec_hit       = 1'b1;
        dec_tag       = TAG_W'(i);
        dec_cache     = REGION_CACHEABLE[i];
        dec_ready     = dn_ready[i];
        dec_onehot    = '0;
        dec_onehot[i] = 1'b1;
      end
    end
  end

  assign req_uncachable = ~dec_cache;
  assign dn_valid       = (req_valid & ~full) ? dec_onehot : '0;
  assign req_ready      = ~full & (dec_hit ? dec_ready : 1'b1);
  assign push           = req_valid & req_ready;

  assign dn_addr  = req_addr;
  assign dn_we    = req_we;
  assign dn_wdata = req_wdata;
  assign dn_strb  = req_strb;

  // Only the region at the FIFO head is allowed to hand back a response.
  always_comb begin
    head_tag    = tag_mem[rd_ptr];
    head_rvalid = 1'b0;
    head_rdata  = '0;
    dn_rready   = '0;
    for (int i = 0; i < NUM_REGION; i++) begin
      if (head_tag == TAG_W'(i)) begin
        head_rvalid  = dn_rvalid[i];
        head_rdata   = dn_rdata[i*XLEN +: XLEN];
        dn_rready[i] = ~empty & resp_free;
      end
    end
  end

  assign map_pop = ~empty & (head_tag != ERR_TAG) & head_rvalid & resp_free;
  assign err_pop = ~empty & (head_tag == ERR_TAG) & resp_free;
  assign pop     = map_pop | err_pop;

  // In-order tag FIFO: the pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem[i] <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= dec_tag;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Response register: load on a pop, otherwise hold until upstream takes it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else if (pop) begin
      resp_valid <= 1'b1;
      resp_data  <= err_pop ? ERR_RDATA : head_rdata;
      resp_err   <= err_pop;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign outstanding = count;

endmodule

// File: tb/tb_ladybird_addr_router.sv
// Directed bench for ladybird_addr_router: each task drives one scenario and
// compares outputs against hand-computed values using the default region table.
module tb_ladybird_addr_router;

  localparam int XLEN = 32;
  localparam int NR   = 6;

  logic            clk;
  logic            nrst;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic            req_we;
  logic [31:0]     req_wdata;
  logic [3:0]      req_strb;
  logic            req_uncachable;
  logic [NR-1:0]   dn_valid;
  logic [NR-1:0]   dn_ready;
  logic [31:0]     dn_addr;
  logic            dn_we;
  logic [31:0]     dn_wdata;
  logic [3:0]      dn_strb;
  logic [NR-1:0]   dn_rvalid;
  logic [NR-1:0]   dn_rready;
  logic [NR*32-1:0] dn_rdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_data;
  logic            resp_err;
  logic [2:0]      outstanding;

  int checks = 0;
  int fails  = 0;

  ladybird_addr_router dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_uncachable(req_uncachable),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_addr(dn_addr),
    .dn_we(dn_we), .dn_wdata(dn_wdata), .dn_strb(dn_strb),
    .dn_rvalid(dn_rvalid), .dn_rready(dn_rready), .dn_rdata(dn_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .outstanding(outstanding)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    nrst = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_wdata = '0; req_strb = '0; dn_ready = '0; dn_rvalid = '0;
    dn_rdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (outstanding !== 3'd0) begin fails++; $display("[TB] FAIL rst_outstanding got=%0d exp=0", outstanding); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_resp_valid got=%0b exp=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin fails++; $display("[TB] FAIL rst_resp_err got=%0b exp=0", resp_err); end
    checks++; if (resp_data !== 32'h0) begin fails++; $display("[TB] FAIL rst_resp_data got=%h exp=0", resp_data); end
    checks++; if (dn_valid !== 6'b0) begin fails++; $display("[TB] FAIL rst_dn_valid got=%b exp=000000", dn_valid); end
    checks++; if (dn_rready !== 6'b0) begin fails++; $display("[TB] FAIL rst_dn_rready got=%b exp=000000", dn_rready); end
    @(negedge clk); nrst = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8000_0010; req_we = 1'b1;
    req_wdata = 32'h1234_5678; req_strb = 4'hF; dn_ready = 6'b000010;
    #1;
    checks++; if (dn_valid !== 6'b000010) begin fails++; $display("[TB] FAIL sr_dn_valid got=%b exp=000010", dn_valid); end
    checks++; if (req_uncachable !== 1'b0) begin fails++; $display("[TB] FAIL sr_uncachable got=%b exp=0", req_uncachable); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL sr_req_ready got=%b exp=1", req_ready); end
    checks++; if (dn_addr !== 32'h8000_0010 || dn_wdata !== 32'h1234_5678 || dn_we !== 1'b1 || dn_strb !== 4'hF)
      begin fails++; $display("[TB] FAIL sr_broadcast got addr=%h wdata=%h we=%b strb=%h", dn_addr, dn_wdata, dn_we, dn_strb); end
    @(posedge clk); #1;
    checks++; if (outstanding !== 3'd1) begin fails++; $display("[TB] FAIL sr_outstanding got=%0d exp=1", outstanding); end
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    dn_rvalid = 6'b000010; dn_rdata[1*32 +: 32] = 32'hCAFE_0A0A;
    #1;
    checks++; if (dn_rready !== 6'b000010) begin fails++; $display("[TB] FAIL sr_dn_rready got=%b exp=000010", dn_rready); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1) begin fails++; $display("[TB] FAIL sr_resp_valid got=%b exp=1", resp_valid); end
    checks++; if (resp_data !== 32'hCAFE_0A0A) begin fails++; $display("[TB] FAIL sr_resp_data got=%h exp=cafe0a0a", resp_data); end
    checks++; if (resp_err !== 1'b0) begin fails++; $display("[TB] FAIL sr_resp_err got=%b exp=0", resp_err); end
    checks++; if (outstanding !== 3'd0) begin fails++; $display("[TB] FAIL sr_outstanding_after got=%0d exp=0", outstanding); end
    @(negedge clk); dn_rvalid = '0;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL sr_resp_drop got=%b exp=0", resp_valid); end
  endtask

  task automatic test_unmapped();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0300_0000; dn_ready = '1;
    #1;
    checks++; if (dn_valid !== 6'b0) begin fails++; $display("[TB] FAIL um_dn_valid got=%b exp=000000", dn_valid); end
    checks++; if (req_uncachable !== 1'b1) begin fails++; $display("[TB] FAIL um_uncachable got=%b exp=1", req_uncachable); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL um_req_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1;
    checks++; if (outstanding !== 3'd1) begin fails++; $display("[TB] FAIL um_outstanding got=%0d exp=1", outstanding); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL um_resp_early got=%b exp=0", resp_valid); end
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1) begin fails++; $display("[TB] FAIL um_resp_valid got=%b exp=1", resp_valid); end
    checks++; if (resp_err !== 1'b1) begin fails++; $display("[TB] FAIL um_resp_err got=%b exp=1", resp_err); end
    checks++; if (resp_data !== 32'h0) begin fails++; $display("[TB] FAIL um_resp_data got=%h exp=00000000", resp_data); end
    checks++; if (outstanding !== 3'd0) begin fails++; $display("[TB] FAIL um_outstanding_after got=%0d exp=0", outstanding); end
    @(posedge clk); #1;
  endtask

  task automatic test_decode_priority();
    @(negedge clk);
    dn_ready = '0; req_valid = 1'b1;
    req_addr = 32'h0000_1234; #1;
    checks++; if (dn_valid !== 6'b000001) begin fails++; $display("[TB] FAIL dp_overlap_dn_valid got=%b exp=000001", dn_valid); end
    checks++; if (req_uncachable !== 1'b0) begin fails++; $display("[TB] FAIL dp_overlap_uncachable got=%b exp=0", req_uncachable); end
    checks++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL dp_not_ready got=%b exp=0", req_ready); end
    req_addr = 32'h0000_2000; #1;
    checks++; if (dn_valid !== 6'b100000) begin fails++; $display("[TB] FAIL dp_r5_dn_valid got=%b exp=100000", dn_valid); end
    checks++; if (req_uncachable !== 1'b1) begin fails++; $display("[TB] FAIL dp_r5_uncachable got=%b exp=1", req_uncachable); end
    req_addr = 32'h1000_0004; #1;
    checks++; if (dn_valid !== 6'b000100) begin fails++; $display("[TB] FAIL dp_r2_dn_valid got=%b exp=000100", dn_valid); end
    checks++; if (req_uncachable !== 1'b1) begin fails++; $display("[TB] FAIL dp_r2_uncachable got=%b exp=1", req_uncachable); end
    @(posedge clk); #1;
    checks++; if (outstanding !== 3'd0) begin fails++; $display("[TB] FAIL dp_no_push got=%0d exp=0", outstanding); end
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    resp_ready = 1'b1; dn_ready = '1; req_valid = 1'b1; req_addr = 32'h0300_0000;
    @(negedge clk);
    req_addr = 32'h0300_0004;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin fails++; $display("[TB] FAIL bb_first_resp got valid=%b err=%b exp 1 1", resp_valid, resp_err); end
    checks++; if (outstanding !== 3'd1) begin fails++; $display("[TB] FAIL bb_push_pop_count got=%0d exp=1", outstanding); end
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin fails++; $display("[TB] FAIL bb_second_resp got valid=%b err=%b exp 1 1", resp_valid, resp_err); end
    checks++; if (outstanding !== 3'd0) begin fails++; $display("[TB] FAIL bb_count_end got=%0d exp=0", outstanding); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("[TB] FAIL bb_resp_drop got=%b exp=0", resp_valid); end
  endtask

  task automatic test_reorder();
    @(negedge clk);
    resp_ready = 1'b1; dn_ready = '1; req_valid = 1'b1; req_addr = 32'h8000_0000;
    @(negedge clk);
    req_addr = 32'h0000_1000;
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (outstanding !== 3'd2) begin fails++; $display("[TB] FAIL ro_outstanding got=%0d exp=2", outstanding); end
    dn_rvalid = 6'b000001; dn_rdata[0 +: 32] = 32'h0000_AAAA;
    #1;
    checks++; if (dn_rready !== 6'b000010) begin fails++; $display("[TB] FAIL ro_hold_r0 got=%b exp=000010", dn_rready); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || outstanding !== 3'd2) begin fails++; $display("[TB] FAIL ro_no_early got valid=%b count=%0d exp 0 2", resp_valid, outstanding); end
    @(negedge clk);
    dn_rvalid = 6'b000011; dn_rdata[1*32 +: 32] = 32'h1111_BBBB;
    #1;
    checks++; if (dn_rready !== 6'b000010) begin fails++; $display("[TB] FAIL ro_head_r1 got=%b exp=000010", dn_rready); end
    @(posedge clk); #1;
    checks++; if (resp_data !== 32'h1111_BBBB || resp_valid !== 1'b1) begin fails++; $display("[TB] FAIL ro_first_data got=%h valid=%b exp=1111bbbb 1", resp_data, resp_valid); end
    @(negedge clk);
    dn_rvalid = 6'b000001;
    #1;
    checks++; if (dn_rready !== 6'b000001) begin fails++; $display("[TB] FAIL ro_head_r0 got=%b exp=000001", dn_rready); end
    @(posedge clk); #1;
    checks++; if (resp_data !== 32'h0000_AAAA || outstanding !== 3'd0) begin fails++; $display("[TB] FAIL ro_second_data got=%h count=%0d exp=0000aaaa 0", resp_data, outstanding); end
    @(negedge clk); dn_rvalid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    resp_ready = 1'b0; dn_ready = '1; req_valid = 1'b1; req_addr = 32'h1000_0000;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (outstanding !== 3'd4) begin fails++; $display("[TB] FAIL sat_full_count got=%0d exp=4", outstanding); end
    checks++; if (req_ready !== 1'b0 || dn_valid !== 6'b0) begin fails++; $display("[TB] FAIL sat_blocked got ready=%b dn_valid=%b exp 0 000000", req_ready, dn_valid); end
    req_valid = 1'b0;
    dn_rvalid = 6'b000100; dn_rdata[2*32 +: 32] = 32'h2222_0001;
    #1;
    checks++; if (dn_rready !== 6'b000100) begin fails++; $display("[TB] FAIL sat_rready got=%b exp=000100", dn_rready); end
    @(posedge clk); #1;
    checks++; if (outstanding !== 3'd3) begin fails++; $display("[TB] FAIL sat_count_3 got=%0d exp=3", outstanding); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL sat_ready_back got=%b exp=1", req_ready); end
    checks++; if (resp_data !== 32'h2222_0001) begin fails++; $display("[TB] FAIL sat_resp_data got=%h exp=22220001", resp_data); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    dn_rdata[2*32 +: 32] = 32'h2222_0002;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (dn_rready !== 6'b0) begin fails++; $display("[TB] FAIL bp_rready_c%0d got=%b exp=000000", c, dn_rready); end
      @(posedge clk); #1;
      checks++; if (resp_data !== 32'h2222_0001 || resp_valid !== 1'b1 || outstanding !== 3'd3)
        begin fails++; $display("[TB] FAIL bp_hold_c%0d got data=%h valid=%b count=%0d exp 22220001 1 3", c, resp_data, resp_valid, outstanding); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midflight();
    #2 nrst = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0 || resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0)
      begin fails++; $display("[TB] FAIL mr_async got count=%0d valid=%b data=%h err=%b exp 0 0 0 0", outstanding, resp_valid, resp_data, resp_err); end
    checks++; if (dn_rready !== 6'b0 || dn_valid !== 6'b0) begin fails++; $display("[TB] FAIL mr_dn got rready=%b valid=%b exp 0 0", dn_rready, dn_valid); end
    dn_rvalid = '0; dn_rdata = '0; resp_ready = 1'b1;
    @(negedge clk); nrst = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h2000_0040;
    #1;
    checks++; if (dn_valid !== 6'b001000 || req_uncachable !== 1'b1) begin fails++; $display("[TB] FAIL mr_decode got dn_valid=%b unc=%b exp 001000 1", dn_valid, req_uncachable); end
    @(posedge clk); #1;
    checks++; if (outstanding !== 3'd1) begin fails++; $display("[TB] FAIL mr_push got=%0d exp=1", outstanding); end
    @(negedge clk);
    req_valid = 1'b0; dn_rvalid = 6'b001000; dn_rdata[3*32 +: 32] = 32'h3333_0003;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h3333_0003 || resp_err !== 1'b0)
      begin fails++; $display("[TB] FAIL mr_resp got valid=%b data=%h err=%b exp 1 33330003 0", resp_valid, resp_data, resp_err); end
    @(negedge clk); dn_rvalid = '0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single_read();
    test_unmapped();
    test_decode_priority();
    test_back_to_back();
    test_reorder();
    test_saturation();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ladybird_addr_router.md
Name: ladybird_addr_router

Overview:
- Parametrised successor to the fixed ROM/DRAM/GPIO access-type decode.
- Routes one upstream core request stream (I_BUS or D_BUS) to NUM_REGION downstream targets using a per-region base/mask table. Flags each accepted request as cacheable or uncacheable.
- Tracks outstanding transactions in order. Steers responses back to the upstream port and synthesises error responses for unmapped addresses.
- Sits between the core bus and the memory/peripheral interconnect.

Parameters:
- XLEN, 32, address/data width.
- NUM_REGION, 6, number of downstream targets.
- MAX_OUTSTANDING, 4, depth of the in-order tracking FIFO (power of two, ≥2).
- REGION_BASE, {NUM_REGION{XLEN}} array, base address of region i.
- REGION_MASK, {NUM_REGION{XLEN}} array, region i matches when (addr & MASK[i]) == BASE[i].
- REGION_CACHEABLE, NUM_REGION bits, bit i set means region i is cacheable.
- ERR_RDATA, 32'h0000_0000, data returned on unmapped access.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- req_valid  in  1  upstream request valid
- req_ready  out  1  upstream request accepted when valid&ready
- req_addr  in  XLEN  request address
- req_we  in  1  write enable
- req_wdata  in  XLEN  write data
- req_strb  in  XLEN/8  byte strobes
- req_uncachable  out  1  combinational decode of req_addr: 1 if unmapped or region not cacheable
- dn_valid  out  NUM_REGION  one-hot downstream request valid
- dn_ready  in  NUM_REGION  downstream ready per region
- dn_addr, dn_we, dn_wdata, dn_strb  out  shared  broadcast copies of the request fields
- dn_rvalid  in  NUM_REGION  downstream response valid
- dn_rready  out  NUM_REGION  downstream response ready
- dn_rdata  in  NUM_REGION*XLEN  flattened response data
- resp_valid  out  1  upstream response valid (registered)
- resp_ready  in  1  upstream response ready
- resp_data  out  XLEN  response data
- resp_err  out  1  response is a decode error
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current tracked count

Behaviour:
- Reset (nrst low, asynchronous):
  - FIFO empty; outstanding = 0.
  - resp_valid = 0, resp_err = 0, resp_data = 0.
  - dn_valid = 0, dn_rready = 0.
  - Reset mid-transaction discards all tracking; downstream targets must be reset in the same domain.
- Decode is combinational and priority-encoded: the lowest index i whose mask/base matches wins. No match means tag ERR.
- Acceptance:
  - FIFO full (outstanding == MAX_OUTSTANDING) forces req_ready = 0, even when the head pops in the same cycle.
  - Mapped address: dn_valid[i] = req_valid & ~full. req_ready = dn_ready[i] & ~full. Handshake pushes tag i.
  - Unmapped address: req_ready = ~full, no dn_valid asserted, pushes tag ERR.
- Response ordering:
  - Only the FIFO head may respond. dn_rready[i] = (head == i) & (~resp_valid | resp_ready). All other dn_rready stay 0.
  - A head tag of ERR produces resp_err = 1 and resp_data = ERR_RDATA. This is loaded into the response register on the cycle the head becomes ERR and the register is free. Minimum latency is 1 cycle after acceptance.
  - A mapped response (dn_rvalid[i] & dn_rready[i]) loads resp_data = dn_rdata[i] and resp_err = 0 on the next clock edge. The FIFO pops on the same edge.
  - The response register holds its value until resp_ready. Back-to-back responses are allowed: a pop and a new load can happen in the same cycle.
- Push and pop in the same cycle (not full) leaves outstanding unchanged. FIFO pointers wrap modulo MAX_OUTSTANDING.
- dn_rvalid on a non-head region is ignored (not acknowledged) until that region reaches the head.

Test Plan:
- Single read, BASE={0x1000,0x8000_0000,…}, MASK={0xFFFF_F000,0x8000_0000,…}:
  - addr 0x8000_0010 → dn_valid = 0b000010, req_uncachable = 0.
  - Region 1 returns 0xCAFE_0A0A → resp_valid one cycle later with resp_data = 0xCAFE_0A0A, resp_err = 0.
- Unmapped addr 0x0300_0000 → no dn_valid; next cycle resp_valid = 1, resp_err = 1, resp_data = ERR_RDATA; req_uncachable = 1.
- Reordering:
  - Issue to region 1, then region 0. Region 0 raises dn_rvalid first.
  - dn_rready[0] must stay 0 until region 1's response is accepted.
  - Upstream sees region 1's data, then region 0's data.
- Saturation:
  - Issue 4 requests with no responses → outstanding = 4, req_ready = 0.
  - Complete one response → outstanding = 3, req_ready returns to 1.
- Backpressure: resp_ready held low for 5 cycles → resp_data stable, dn_rready all 0, no FIFO pop.
- Reset with outstanding = 3 and resp_valid = 1 → outputs return to reset values immediately; after release the next request decodes normally.
